// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve
//   Direct-mapped BTB with 2-bit saturating counters, looked up with the IF PC,
//   plus combinational ID-stage resolution of BEQ/BNE/J/JAL/JR against the
//   prediction carried down the pipe. Trains the table on retired transfers.
//   Optional performance counters are built when BRU_PERF_CNT_EN is defined;
//   otherwise br_count_o/mp_count_o are tied to zero.
module branch_predict_resolve #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        id_valid_i,
    input  logic        stall_i,
    input  logic        exception_i,
    input  logic [31:0] id_pc_i,
    input  logic [5:0]  id_op_i,
    input  logic [5:0]  id_func_i,
    input  logic [15:0] id_imm_i,
    input  logic [25:0] id_tgt26_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        id_pred_taken_i,
    input  logic [31:0] id_pred_target_i,
    output logic        is_branch_o,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] br_count_o,
    output logic [31:0] mp_count_o
);

    localparam int DEPTH = 2 ** IDX_W;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;

    logic             valid_q [DEPTH];
    logic [1:0]       ctr_q   [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [31:0]      tgt_q   [DEPTH];

    logic [IDX_W-1:0] if_idx, id_idx;
    logic [TAG_W-1:0] if_tag, id_tag;
    logic             id_hit;

    logic        is_beq, is_bne, is_jmp, is_jr, cti;
    logic        taken;
    logic [31:0] pc_plus4, br_tgt, j_tgt, target;
    logic        act, upd;
    logic        unused_pc;

    assign if_idx    = if_pc_i[IDX_W+1:2];
    assign if_tag    = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign id_idx    = id_pc_i[IDX_W+1:2];
    assign id_tag    = id_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc = ^{if_pc_i[31:IDX_W+TAG_W+2], if_pc_i[1:0]};

    // IF lookup: purely combinational, no bypass of a same-cycle write
    always_comb begin
        pred_taken_o  = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && ctr_q[if_idx][1];
        pred_target_o = pred_taken_o ? tgt_q[if_idx] : 32'h0;
    end

    // ID decode, target generation and taken decision
    always_comb begin
        is_beq   = (id_op_i == OP_BEQ);
        is_bne   = (id_op_i == OP_BNE);
        is_jmp   = (id_op_i == OP_J) || (id_op_i == OP_JAL);
        is_jr    = (id_op_i == OP_SPECIAL) && (id_func_i == FN_JR);
        cti      = is_beq || is_bne || is_jmp || is_jr;
        pc_plus4 = id_pc_i + 32'd4;
        br_tgt   = pc_plus4 + {{14{id_imm_i[15]}}, id_imm_i, 2'b00};
        j_tgt    = {pc_plus4[31:28], id_tgt26_i, 2'b00};
        taken    = 1'b0;
        target   = 32'h0;
        if (is_beq) begin
            taken  = (rs_data_i == rt_data_i);
            target = br_tgt;
        end else if (is_bne) begin
            taken  = (rs_data_i != rt_data_i);
            target = br_tgt;
        end else if (is_jmp) begin
            taken  = 1'b1;
            target = j_tgt;
        end else if (is_jr) begin
            taken  = 1'b1;
            target = rs_data_i;
        end
    end

    // Resolution outputs; a non-CTI predicted taken (tag alias) also mispredicts
    always_comb begin
        act           = id_valid_i && !exception_i && !rst;
        is_branch_o   = act && cti && taken;
        mispredict_o  = act && ((taken != id_pred_taken_i) ||
                                (taken && (target != id_pred_target_i)));
        redirect_pc_o = act ? (taken ? target : pc_plus4) : 32'h0;
        upd           = act && !stall_i && (cti || id_pred_taken_i);
        id_hit        = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    end

    // Table training; stalls hold off the write so each instruction trains once
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
                tag_q[i]   <= '0;
                tgt_q[i]   <= 32'h0;
            end
        end else if (upd) begin
            if (id_hit && cti) begin
                if (taken) begin
                    if (ctr_q[id_idx] != 2'b11) ctr_q[id_idx] <= ctr_q[id_idx] + 2'b01;
                    tgt_q[id_idx] <= target;
                end else if (ctr_q[id_idx] != 2'b00) begin
                    ctr_q[id_idx] <= ctr_q[id_idx] - 2'b01;
                end
            end else if (id_hit) begin
                valid_q[id_idx] <= 1'b0;
            end else if (taken) begin
                valid_q[id_idx] <= 1'b1;
                tag_q[id_idx]   <= id_tag;
                tgt_q[id_idx]   <= target;
                ctr_q[id_idx]   <= 2'b10;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt_q, mp_cnt_q;

    // Saturating retired-transfer and mispredict counters
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= 32'h0;
            mp_cnt_q <= 32'h0;
        end else begin
            if (upd && cti && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
            if (upd && mispredict_o && (mp_cnt_q != 32'hFFFF_FFFF)) mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign br_count_o = br_cnt_q;
    assign mp_count_o = mp_cnt_q;
`else
    assign br_count_o = 32'h0;
    assign mp_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed scenarios plus a randomized run
// against a behavioural BTB model.
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid = 0, stall = 0, exception = 0;
    logic [31:0] id_pc = 0;
    logic [5:0]  id_op = 0, id_func = 0;
    logic [15:0] id_imm = 0;
    logic [25:0] id_tgt26 = 0;
    logic [31:0] rs_data = 0, rt_data = 0;
    logic        id_pred_taken = 0;
    logic [31:0] id_pred_target = 0;
    logic        is_branch, mispredict;
    logic [31:0] redirect_pc, br_count, mp_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

`ifdef BRU_PERF_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    branch_predict_resolve dut (
        .clk(clk), .rst(rst), .if_pc_i(if_pc),
        .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .id_valid_i(id_valid), .stall_i(stall), .exception_i(exception),
        .id_pc_i(id_pc), .id_op_i(id_op), .id_func_i(id_func),
        .id_imm_i(id_imm), .id_tgt26_i(id_tgt26),
        .rs_data_i(rs_data), .rt_data_i(rt_data),
        .id_pred_taken_i(id_pred_taken), .id_pred_target_i(id_pred_target),
        .is_branch_o(is_branch), .mispredict_o(mispredict),
        .redirect_pc_o(redirect_pc), .br_count_o(br_count), .mp_count_o(mp_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid [64];
    int          m_ctr   [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    longint      m_br, m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return (pc / 256) % 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_br = 0; m_mp = 0;
    endtask

    task automatic ref_res(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc,
                           input logic [15:0] imm, input logic [25:0] t26,
                           input logic [31:0] rs, input logic [31:0] rt,
                           output bit cti, output bit tk, output logic [31:0] tgt);
        int off;
        off = int'($signed(imm));
        cti = 1; tk = 0; tgt = 0;
        if (op == 6'h04)      begin tk = (rs == rt); tgt = pc + 32'd4 + 32'(off * 4); end
        else if (op == 6'h05) begin tk = (rs != rt); tgt = pc + 32'd4 + 32'(off * 4); end
        else if (op == 6'h02 || op == 6'h03) begin
            tk = 1; tgt = ((pc + 32'd4) & 32'hF000_0000) + 32'(t26) * 32'd4;
        end
        else if (op == 6'h00 && fn == 6'h08) begin tk = 1; tgt = rs; end
        else cti = 0;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc,
                          input logic [15:0] imm, input logic [25:0] t26,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic pt, input logic [31:0] ptgt);
        id_valid = 1; stall = 0; exception = 0;
        id_op = op; id_func = fn; id_pc = pc; id_imm = imm; id_tgt26 = t26;
        rs_data = rs; rt_data = rt; id_pred_taken = pt; id_pred_target = ptgt;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1;
        set_id(6'h02, 6'h00, 32'h100, 16'h0, 26'h40, 0, 0, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_cnt++; if (is_branch !== 1'b0) $display("FAIL reset_is_branch got %0h exp 0", is_branch); else pass_cnt++;
        chk_cnt++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got %0h exp 0", mispredict); else pass_cnt++;
        chk_cnt++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect got %0h exp 0", redirect_pc); else pass_cnt++;
        chk_cnt++; if (pred_taken !== 1'b0 || pred_target !== 32'h0)
            $display("FAIL reset_pred got %0h/%0h exp 0/0", pred_taken, pred_target); else pass_cnt++;
        chk_cnt++; if (br_count !== 32'h0 || mp_count !== 32'h0)
            $display("FAIL reset_counts got %0h/%0h exp 0/0", br_count, mp_count); else pass_cnt++;
        id_valid = 0;
    endtask

    task automatic test_beq_alloc();
        @(negedge clk); rst = 0;
        set_id(6'h04, 6'h00, 32'h100, 16'd4, 26'h0, 5, 5, 1'b0, 0);
        if_pc = 32'h100; #1;
        chk_cnt++; if (pred_taken !== 1'b0) $display("FAIL t1_pred_before got %0h exp 0", pred_taken); else pass_cnt++;
        chk_cnt++; if (is_branch !== 1'b1 || mispredict !== 1'b1)
            $display("FAIL t1_resolve got ib=%0h mp=%0h exp 1/1", is_branch, mispredict); else pass_cnt++;
        chk_cnt++; if (redirect_pc !== 32'h114) $display("FAIL t1_redirect got %0h exp 114", redirect_pc); else pass_cnt++;
        @(negedge clk); id_valid = 0; #1;
        chk_cnt++; if (pred_taken !== 1'b1 || pred_target !== 32'h114)
            $display("FAIL t1_pred_after got %0h/%0h exp 1/114", pred_taken, pred_target); else pass_cnt++;
        chk_cnt++; if (mispredict !== 1'b0) $display("FAIL t1_idle_mp got %0h exp 0", mispredict); else pass_cnt++;
    endtask

    task automatic test_beq_train();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_id(6'h04, 6'h00, 32'h100, 16'd4, 26'h0, 5, 5, 1'b1, 32'h114); #1;
            chk_cnt++; if (mispredict !== 1'b0) $display("FAIL t2_train_mp[%0d] got %0h exp 0", i, mispredict); else pass_cnt++;
        end
        @(negedge clk);
        set_id(6'h04, 6'h00, 32'h100, 16'd4, 26'h0, 5, 6, 1'b1, 32'h114); #1;
        chk_cnt++; if (mispredict !== 1'b1 || is_branch !== 1'b0)
            $display("FAIL t2_nt_resolve got mp=%0h ib=%0h exp 1/0", mispredict, is_branch); else pass_cnt++;
        chk_cnt++; if (redirect_pc !== 32'h104) $display("FAIL t2_redirect got %0h exp 104", redirect_pc); else pass_cnt++;
        @(negedge clk); id_valid = 0; if_pc = 32'h100; #1;
        chk_cnt++; if (pred_taken !== 1'b1) $display("FAIL t2_still_taken got %0h exp 1", pred_taken); else pass_cnt++;
        @(negedge clk);
        set_id(6'h04, 6'h00, 32'h100, 16'd4, 26'h0, 5, 6, 1'b1, 32'h114);
        @(negedge clk); id_valid = 0; #1;
        chk_cnt++; if (pred_taken !== 1'b0) $display("FAIL t2_weak_nt got %0h exp 0", pred_taken); else pass_cnt++;
    endtask

    task automatic test_jr_retarget();
        @(negedge clk);
        set_id(6'h00, 6'h08, 32'h200, 16'h0, 26'h0, 32'h300, 0, 1'b0, 0); #1;
        chk_cnt++; if (redirect_pc !== 32'h300 || mispredict !== 1'b1)
            $display("FAIL t3_alloc got rd=%0h mp=%0h exp 300/1", redirect_pc, mispredict); else pass_cnt++;
        @(negedge clk);
        set_id(6'h00, 6'h08, 32'h200, 16'h0, 26'h0, 32'h400, 0, 1'b1, 32'h300);
        if_pc = 32'h200; #1;
        chk_cnt++; if (pred_taken !== 1'b1 || pred_target !== 32'h300)
            $display("FAIL t3_pred got %0h/%0h exp 1/300", pred_taken, pred_target); else pass_cnt++;
        chk_cnt++; if (mispredict !== 1'b1 || redirect_pc !== 32'h400)
            $display("FAIL t3_resolve got mp=%0h rd=%0h exp 1/400", mispredict, redirect_pc); else pass_cnt++;
        @(negedge clk); id_valid = 0; #1;
        chk_cnt++; if (pred_target !== 32'h400) $display("FAIL t3_new_target got %0h exp 400", pred_target); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [31:0] br0, mp0;
        br0 = br_count; mp0 = mp_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_id(6'h05, 6'h00, 32'h180, 16'd8, 26'h0, 1, 2, 1'b0, 0);
            stall = (i < 3); #1;
            chk_cnt++; if (mispredict !== 1'b1) $display("FAIL t4_mp_held[%0d] got %0h exp 1", i, mispredict); else pass_cnt++;
        end
        @(negedge clk); id_valid = 0; stall = 0; if_pc = 32'h180; #1;
        chk_cnt++; if (pred_taken !== 1'b1 || pred_target !== 32'h1A4)
            $display("FAIL t4_alloc got %0h/%0h exp 1/1a4", pred_taken, pred_target); else pass_cnt++;
        chk_cnt++; if (br_count !== (EN ? br0 + 32'd1 : 32'h0))
            $display("FAIL t4_br_count got %0h exp %0h", br_count, EN ? br0 + 32'd1 : 32'h0); else pass_cnt++;
        chk_cnt++; if (mp_count !== (EN ? mp0 + 32'd1 : 32'h0))
            $display("FAIL t4_mp_count got %0h exp %0h", mp_count, EN ? mp0 + 32'd1 : 32'h0); else pass_cnt++;
        @(negedge clk);
        set_id(6'h05, 6'h00, 32'h180, 16'd8, 26'h0, 3, 3, 1'b1, 32'h1A4); #1;
        chk_cnt++; if (redirect_pc !== 32'h184) $display("FAIL t4_nt_redirect got %0h exp 184", redirect_pc); else pass_cnt++;
        @(negedge clk); id_valid = 0; #1;
        chk_cnt++; if (pred_taken !== 1'b0) $display("FAIL t4_single_update got %0h exp 0", pred_taken); else pass_cnt++;
    endtask

    task automatic test_exception_rst();
        @(negedge clk);
        set_id(6'h02, 6'h00, 32'h300, 16'h0, 26'h40, 0, 0, 1'b0, 0);
        exception = 1; #1;
        chk_cnt++; if (is_branch !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h0)
            $display("FAIL t5_exc got ib=%0h mp=%0h rd=%0h exp 0/0/0", is_branch, mispredict, redirect_pc); else pass_cnt++;
        @(negedge clk); id_valid = 0; exception = 0; if_pc = 32'h300; #1;
        chk_cnt++; if (pred_taken !== 1'b0) $display("FAIL t5_no_write got %0h exp 0", pred_taken); else pass_cnt++;
        @(negedge clk);
        set_id(6'h02, 6'h00, 32'h340, 16'h0, 26'h40, 0, 0, 1'b0, 0);
        rst = 1; #1;
        chk_cnt++; if (is_branch !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h0)
            $display("FAIL t5_rst_out got ib=%0h mp=%0h rd=%0h exp 0/0/0", is_branch, mispredict, redirect_pc); else pass_cnt++;
        @(negedge clk); rst = 0; id_valid = 0; if_pc = 32'h340; #1;
        chk_cnt++; if (pred_taken !== 1'b0) $display("FAIL t5_rst_discard got %0h exp 0", pred_taken); else pass_cnt++;
        if_pc = 32'h200; #1;
        chk_cnt++; if (pred_taken !== 1'b0) $display("FAIL t5_rst_clear got %0h exp 0", pred_taken); else pass_cnt++;
        chk_cnt++; if (br_count !== 32'h0 || mp_count !== 32'h0)
            $display("FAIL t5_rst_counts got %0h/%0h exp 0/0", br_count, mp_count); else pass_cnt++;
    endtask

    task automatic test_alias();
        @(negedge clk);
        set_id(6'h04, 6'h00, 32'h100, 16'd4, 26'h0, 7, 7, 1'b0, 0);
        @(negedge clk);
        set_id(6'h00, 6'h20, 32'h10100, 16'h0, 26'h0, 7, 7, 1'b1, 32'h114);
        if_pc = 32'h10100; #1;
        chk_cnt++; if (pred_taken !== 1'b1) $display("FAIL t6_alias_hit got %0h exp 1", pred_taken); else pass_cnt++;
        chk_cnt++; if (mispredict !== 1'b1 || is_branch !== 1'b0 || redirect_pc !== 32'h10104)
            $display("FAIL t6_alias got mp=%0h ib=%0h rd=%0h exp 1/0/10104", mispredict, is_branch, redirect_pc); else pass_cnt++;
        @(negedge clk); id_valid = 0; if_pc = 32'h100; #1;
        chk_cnt++; if (pred_taken !== 1'b0) $display("FAIL t6_invalidated got %0h exp 0", pred_taken); else pass_cnt++;
        chk_cnt++; if (br_count !== (EN ? 32'd1 : 32'd0) || mp_count !== (EN ? 32'd2 : 32'd0))
            $display("FAIL t6_counts got %0h/%0h exp %0h/%0h", br_count, mp_count,
                     EN ? 1 : 0, EN ? 2 : 0); else pass_cnt++;
    endtask

    // ---------------- randomized run against the model ----------------
    function automatic logic [31:0] rpc();
        return 32'($urandom_range(0, 1)) * 32'h10000 + 32'($urandom_range(0, 3)) * 32'h100
             + 32'($urandom_range(0, 3)) * 32'h4;
    endfunction

    task automatic test_random();
        logic [5:0]  ops [7];
        logic [31:0] pool [4];
        bit          cti, tk, act, e_ib, e_mp, e_pt, hit;
        logic [31:0] tgt, e_rd, e_ptgt;
        int          k, ix;
        ops[0] = 6'h04; ops[1] = 6'h05; ops[2] = 6'h02; ops[3] = 6'h03;
        ops[4] = 6'h00; ops[5] = 6'h00; ops[6] = 6'h23;
        pool[0] = 32'h5; pool[1] = 32'h6; pool[2] = 32'h400; pool[3] = 32'h8000;
        @(negedge clk); rst = 1; id_valid = 0;
        @(negedge clk); rst = 0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 49) == 0);
            id_valid  = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            exception = ($urandom_range(0, 7) == 0);
            id_pc     = rpc();
            if_pc     = rpc();
            k         = $urandom_range(0, 6);
            id_op     = ops[k];
            id_func   = (k == 4) ? 6'h08 : 6'h20;
            id_imm    = 16'($urandom_range(0, 15) - 8);
            id_tgt26  = 26'($urandom_range(0, 1023));
            rs_data   = pool[$urandom_range(0, 3)];
            rt_data   = pool[$urandom_range(0, 1)];
            ref_res(id_op, id_func, id_pc, id_imm, id_tgt26, rs_data, rt_data, cti, tk, tgt);
            id_pred_taken  = $urandom_range(0, 1);
            id_pred_target = $urandom_range(0, 1) ? tgt : id_pc + 32'd8;
            #1;
            act  = id_valid && !exception && !rst;
            e_ib = act && cti && tk;
            e_mp = act && ((tk != id_pred_taken) || (tk && tgt != id_pred_target));
            e_rd = act ? (tk ? tgt : id_pc + 32'd4) : 32'h0;
            ix   = idx_of(if_pc);
            e_pt = m_valid[ix] && (m_tag[ix] == tag_of(if_pc)) && (m_ctr[ix] >= 2);
            e_ptgt = m_tgt[ix];
            chk_cnt++; if (pred_taken !== e_pt) $display("FAIL rnd_pred_taken[%0d] got %0h exp %0h", n, pred_taken, e_pt); else pass_cnt++;
            if (e_pt) begin
                chk_cnt++; if (pred_target !== e_ptgt) $display("FAIL rnd_pred_target[%0d] got %0h exp %0h", n, pred_target, e_ptgt); else pass_cnt++;
            end
            chk_cnt++; if (is_branch !== e_ib) $display("FAIL rnd_is_branch[%0d] got %0h exp %0h", n, is_branch, e_ib); else pass_cnt++;
            chk_cnt++; if (mispredict !== e_mp) $display("FAIL rnd_mispredict[%0d] got %0h exp %0h", n, mispredict, e_mp); else pass_cnt++;
            chk_cnt++; if (redirect_pc !== e_rd) $display("FAIL rnd_redirect[%0d] got %0h exp %0h", n, redirect_pc, e_rd); else pass_cnt++;
            chk_cnt++; if (br_count !== (EN ? 32'(m_br) : 32'h0) || mp_count !== (EN ? 32'(m_mp) : 32'h0))
                $display("FAIL rnd_counts[%0d] got %0h/%0h exp %0h/%0h", n, br_count, mp_count,
                         EN ? m_br : 0, EN ? m_mp : 0); else pass_cnt++;
            if (rst) begin
                model_reset();
            end else if (act && !stall && (cti || id_pred_taken)) begin
                if (cti && m_br < 64'hFFFF_FFFF) m_br++;
                if (e_mp && m_mp < 64'hFFFF_FFFF) m_mp++;
                ix  = idx_of(id_pc);
                hit = m_valid[ix] && (m_tag[ix] == tag_of(id_pc));
                if (hit && cti) begin
                    if (tk) begin
                        m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
                        m_tgt[ix] = tgt;
                    end else begin
                        m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
                    end
                end else if (hit) begin
                    m_valid[ix] = 0;
                end else if (tk) begin
                    m_valid[ix] = 1; m_tag[ix] = tag_of(id_pc); m_tgt[ix] = tgt; m_ctr[ix] = 2;
                end
            end
        end
        @(negedge clk); rst = 0; id_valid = 0; stall = 0; exception = 0;
    endtask

    initial begin
        test_reset();
        test_beq_alloc();
        test_beq_train();
        test_jr_retarget();
        test_stall();
        test_exception_rst();
        test_alias();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
